// File: rtl/ft600_bus_sched_pkg.sv
// ---------------------------------------------------------------------------
// ft600_pkg : shared types and constants for the FT600 bus scheduler
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ft600_pkg;

  localparam int          DATA_W_DEF = 16;
  localparam int          CNT_W      = 16;
  localparam logic [1:0]  BE_ALL     = 2'b11;
  localparam logic        DIR_RX     = 1'b0;
  localparam logic        DIR_TX     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_OE  = 3'd1,
    ST_RX     = 3'd2,
    ST_RX_END = 3'd3,
    ST_TX     = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ft600_bus_sched_if.sv
// ---------------------------------------------------------------------------
// ft600_bus_sched_if : FT600 pin-side and FIFO-side signals of the scheduler
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ft600_bus_sched_if
  import ft600_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              ft_rxf_n;
  logic              ft_txe_n;
  logic [DATA_W-1:0] ft_data_in;
  logic [DATA_W-1:0] ft_data_out;
  logic              ft_data_oe;
  logic [1:0]        ft_be_out;
  logic              ft_oe_n;
  logic              ft_rd_n;
  logic              ft_wr_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_wr_en;
  logic              rx_afull;
  logic [DATA_W-1:0] tx_data;
  logic              tx_empty;
  logic              tx_rd_en;

  modport master (
    input  ft_rxf_n, ft_txe_n, ft_data_in, rx_afull, tx_data, tx_empty,
    output ft_data_out, ft_data_oe, ft_be_out, ft_oe_n, ft_rd_n, ft_wr_n,
           rx_data, rx_wr_en, tx_rd_en
  );

  modport slave (
    output ft_rxf_n, ft_txe_n, ft_data_in, rx_afull, tx_data, tx_empty,
    input  ft_data_out, ft_data_oe, ft_be_out, ft_oe_n, ft_rd_n, ft_wr_n,
           rx_data, rx_wr_en, tx_rd_en
  );

endinterface

`default_nettype wire

// File: rtl/ft600_bus_sched_burst_cnt.sv
// ---------------------------------------------------------------------------
// ft600_burst_cnt : per-grant word counter with burst-limit detection
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ft600_burst_cnt
  import ft600_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Hit flags the transfer that completes the burst, so exit happens at its edge.
  assign hit_o = inc_i && (cnt_q == LAST_IDX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft600_bus_sched.sv
// ---------------------------------------------------------------------------
// ft600_bus_sched : half-duplex direction scheduler for the FT600 245 FIFO bus
//                   Optional FT600_STATS_EN adds rx_count / tx_count outputs.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ft600_bus_sched
  import ft600_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  ft600_bus_sched_if.master  bus,
  output logic               busy
`ifdef FT600_STATS_EN
  ,
  output logic [31:0]        rx_count,
  output logic [31:0]        tx_count
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic              last_dir_q;
  logic              last_dir_d;
  logic              rx_req;
  logic              tx_req;
  logic              rx_xfer;
  logic              tx_xfer;
  logic              cnt_clr;
  logic              cnt_hit;
  logic [DATA_W-1:0] tx_word;

  assign rx_req  = !bus.ft_rxf_n && !bus.rx_afull;
  assign tx_req  = !bus.ft_txe_n && !bus.tx_empty;
  assign tx_word = bus.tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_TX;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
    end
  end

  // On a tie the direction not served last wins, so neither side starves.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_req && (!tx_req || last_dir_q == DIR_TX)) begin
          state_d    = ST_RX_OE;
          last_dir_d = DIR_RX;
        end else if (tx_req) begin
          state_d    = ST_TX;
          last_dir_d = DIR_TX;
        end
      end
      ST_RX_OE:  state_d = ST_RX;
      ST_RX: begin
        if (bus.ft_rxf_n || bus.rx_afull || cnt_hit) begin
          state_d = ST_RX_END;
        end
      end
      ST_RX_END: state_d = ST_IDLE;
      ST_TX: begin
        if (bus.ft_txe_n || bus.tx_empty || cnt_hit) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ft_oe_n     = 1'b1;
    bus.ft_rd_n     = 1'b1;
    bus.ft_data_oe  = 1'b0;
    bus.ft_be_out   = 2'b00;
    bus.ft_data_out = '0;
    rx_xfer         = 1'b0;
    tx_xfer         = 1'b0;
    unique case (state_q)
      ST_RX_OE: begin
        bus.ft_oe_n = 1'b0;
      end
      ST_RX: begin
        bus.ft_oe_n = 1'b0;
        bus.ft_rd_n = 1'b0;
        rx_xfer     = !bus.ft_rxf_n;
      end
      ST_TX: begin
        bus.ft_data_oe  = 1'b1;
        bus.ft_be_out   = BE_ALL;
        bus.ft_data_out = tx_word;
        tx_xfer         = tx_req;
      end
      default: ;
    endcase
    bus.rx_wr_en = rx_xfer;
    bus.tx_rd_en = tx_xfer;
    bus.ft_wr_n  = !tx_xfer;
  end

  assign bus.rx_data = bus.ft_data_in;
  assign busy        = (state_q != ST_IDLE);
  assign cnt_clr     = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  ft600_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (rx_xfer || tx_xfer),
    .hit_o (cnt_hit)
  );

`ifdef FT600_STATS_EN
  logic [31:0] rx_count_q;
  logic [31:0] tx_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      if (rx_xfer) rx_count_q <= rx_count_q + 32'd1;
      if (tx_xfer) tx_count_q <= tx_count_q + 32'd1;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ft600_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_ft600_bus_sched : directed self-checking bench for ft600_bus_sched
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ft600_bus_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic busy4;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ft600_bus_sched_if #(.DATA_W(16)) bus ();
  ft600_bus_sched_if #(.DATA_W(16)) bus4 ();

`ifdef FT600_STATS_EN
  logic [31:0] rx_count, tx_count, rx_count4, tx_count4;
`endif

  ft600_bus_sched #(.DATA_W(16), .MAX_BURST(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef FT600_STATS_EN
    ,
    .rx_count (rx_count),
    .tx_count (tx_count)
`endif
  );

  ft600_bus_sched #(.DATA_W(16), .MAX_BURST(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .busy  (busy4)
`ifdef FT600_STATS_EN
    ,
    .rx_count (rx_count4),
    .tx_count (tx_count4)
`endif
  );

  // {oe_n, rd_n, wr_n, data_oe, rx_wr_en, tx_rd_en, busy}
  logic [6:0] st;
  assign st = {bus.ft_oe_n, bus.ft_rd_n, bus.ft_wr_n, bus.ft_data_oe,
               bus.rx_wr_en, bus.tx_rd_en, busy};

  typedef struct {
    logic        rxf_n;
    logic        afull;
    logic [15:0] din;
    logic [6:0]  exp;
  } vec_t;

  vec_t        v[18];
  logic [15:0] txq[$];
  logic [15:0] txexp[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic [15:0] d,
                              input logic [6:0] e);
    vec_t t;
    t.rxf_n = r; t.afull = a; t.din = d; t.exp = e;
    return t;
  endfunction

  initial begin
    int rx_pulses;
    int idle_err;
    int ntx;
    int bdir[8];
    int blen[8];
    int nb;
    int cur;
    int pdir;
    int gap;
    int mingap;
    int ovlp;

    bus.ft_rxf_n = 1'b1;  bus.ft_txe_n = 1'b1;  bus.ft_data_in = '0;
    bus.rx_afull = 1'b0;  bus.tx_data  = '0;    bus.tx_empty   = 1'b1;
    bus4.ft_rxf_n = 1'b1; bus4.ft_txe_n = 1'b1; bus4.ft_data_in = '0;
    bus4.rx_afull = 1'b0; bus4.tx_data  = '0;   bus4.tx_empty   = 1'b1;

    // RX 5-word burst, then rx_afull raised on the 3rd word of a second burst
    v[0]  = mk(1'b0, 1'b0, 16'h0000, 7'b1110000);
    v[1]  = mk(1'b0, 1'b0, 16'h0000, 7'b0110001);
    for (int i = 2; i <= 6; i++) v[i] = mk(1'b0, 1'b0, 16'h1000 + 16'(i), 7'b0010101);
    v[7]  = mk(1'b1, 1'b0, 16'h0000, 7'b0010001);
    v[8]  = mk(1'b1, 1'b0, 16'h0000, 7'b1110001);
    v[9]  = mk(1'b1, 1'b0, 16'h0000, 7'b1110000);
    v[10] = mk(1'b0, 1'b0, 16'h0000, 7'b1110000);
    v[11] = mk(1'b0, 1'b0, 16'h0000, 7'b0110001);
    v[12] = mk(1'b0, 1'b0, 16'h2001, 7'b0010101);
    v[13] = mk(1'b0, 1'b0, 16'h2002, 7'b0010101);
    v[14] = mk(1'b0, 1'b1, 16'h2003, 7'b0010101);
    v[15] = mk(1'b0, 1'b1, 16'h0000, 7'b1110001);
    v[16] = mk(1'b0, 1'b1, 16'h0000, 7'b1110000);
    v[17] = mk(1'b1, 1'b0, 16'h0000, 7'b1110000);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", 32'(st), 32'b1110000);
    chk("rst_be", 32'(bus.ft_be_out), 32'd0);
    chk("rst_dout", 32'(bus.ft_data_out), 32'd0);
`ifdef FT600_STATS_EN
    chk("rst_rx_count", rx_count, 32'd0);
    chk("rst_tx_count", tx_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_err = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (st !== 7'b1110000 || busy4 !== 1'b0 || bus.ft_be_out !== 2'b00) idle_err++;
    end
    chk("idle_100", 32'(idle_err), 32'd0);

    rx_pulses = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.ft_rxf_n   = v[i].rxf_n;
      bus.rx_afull   = v[i].afull;
      bus.ft_data_in = v[i].din;
      #1;
      chk($sformatf("vec%0d", i), 32'(st), 32'(v[i].exp));
      if (v[i].exp[2]) chk($sformatf("vec%0d_rxdata", i), 32'(bus.rx_data), 32'(v[i].din));
      if (bus.rx_wr_en === 1'b1) rx_pulses++;
      if (i == 9) chk("rx_burst5_pulses", 32'(rx_pulses), 32'd5);
    end
    chk("rx_total_pulses", 32'(rx_pulses), 32'd8);

    // TX: FIFO model with three words, popped on every tx_rd_en
    txexp = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    txq = {16'hA1B2, 16'hC3D4, 16'hE5F6};
    ntx = 0;
    bus.ft_txe_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.tx_empty = (txq.size() == 0);
      bus.tx_data  = (txq.size() != 0) ? txq[0] : 16'h0000;
      #1;
      if (bus.tx_rd_en === 1'b1) begin
        chk("tx_wr_n", 32'(bus.ft_wr_n), 32'd0);
        chk("tx_be", 32'(bus.ft_be_out), 32'd3);
        if (ntx < 3) chk($sformatf("tx_word%0d", ntx), 32'(bus.ft_data_out), 32'(txexp[ntx]));
        ntx++;
        if (txq.size() != 0) void'(txq.pop_front());
      end
    end
    chk("tx_words", 32'(ntx), 32'd3);
    chk("tx_oe_after", 32'(bus.ft_data_oe), 32'd0);
    chk("tx_busy_after", 32'(busy), 32'd0);
    bus.ft_txe_n = 1'b1;
`ifdef FT600_STATS_EN
    chk("stat_rx_count", rx_count, 32'd8);
    chk("stat_tx_count", tx_count, 32'd3);
`endif

    // Both directions requesting continuously on the MAX_BURST=4 instance
    bus4.ft_rxf_n = 1'b0; bus4.ft_txe_n = 1'b0; bus4.tx_empty = 1'b0;
    nb = 0; cur = -1; pdir = -1; gap = 0; mingap = 99; ovlp = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      bus4.tx_data    = 16'h4000 + 16'(c);
      bus4.ft_data_in = 16'h8000 + 16'(c);
      #1;
      if (bus4.ft_data_oe === 1'b1 && bus4.ft_oe_n === 1'b0) ovlp++;
      if (bus4.rx_wr_en === 1'b1 || bus4.tx_rd_en === 1'b1) begin
        if (cur == -1) begin
          cur = (bus4.rx_wr_en === 1'b1) ? 0 : 1;
          if (pdir == 0 && cur == 1 && gap < mingap) mingap = gap;
          if (nb < 8) begin
            bdir[nb] = cur;
            blen[nb] = 0;
          end
          nb++;
          pdir = cur;
        end
        if (nb <= 8) blen[nb-1]++;
        gap = 0;
      end else begin
        cur = -1;
        gap++;
      end
    end
    chk("alt_nbursts_ge4", 32'(nb >= 4), 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (b < nb) begin
        chk($sformatf("alt_dir%0d", b), 32'(bdir[b]), 32'(b % 2));
        chk($sformatf("alt_len%0d", b), 32'(blen[b]), 32'd4);
      end
    end
    chk("alt_no_overlap", 32'(ovlp), 32'd0);
    chk("alt_turnaround", 32'(mingap >= 2), 32'd1);
    bus4.ft_rxf_n = 1'b1; bus4.ft_txe_n = 1'b1; bus4.tx_empty = 1'b1;

    // Asynchronous reset in the middle of a TX burst
    @(negedge clk);
    bus.tx_empty = 1'b0; bus.tx_data = 16'h5A5A; bus.ft_txe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_wr_n", 32'(bus.ft_wr_n), 32'd0);
    chk("pre_rst_oe", 32'(bus.ft_data_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", 32'(bus.ft_wr_n), 32'd1);
    chk("mid_rst_oe", 32'(bus.ft_data_oe), 32'd0);
    chk("mid_rst_strobes", 32'(st), 32'b1110000);
`ifdef FT600_STATS_EN
    chk("mid_rst_rx_count", rx_count, 32'd0);
    chk("mid_rst_tx_count", tx_count, 32'd0);
`endif
    bus.ft_txe_n = 1'b1; bus.tx_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(st), 32'b1110000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ft600_bus_sched.md
# ft600_bus_sched

Direction scheduler for the FT600 245-synchronous FIFO bus. It shares the single half-duplex 16-bit bus between the receive path (FT600 → FPGA RX FIFO) and the transmit path (TX FIFO → FT600). It generates `ft_oe_n`, `ft_rd_n`, `ft_wr_n`, the byte enables and the data-bus drive enable, and enforces the bus turnaround. It sits between the FT600 pins (tristate resolved in `main`) and the RX/TX buffers, clocked by `ft_clk`.

## Interface
- `DATA_W`, 16: FT600 data bus width.
- `MAX_BURST`, 64: maximum words per grant before re-arbitration; legal range 1..65535.
- `clk`  in  1: FT600 clock (`ft_clk` at top level); sole clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `ft_rxf_n`  in  1: FT600 has data to read (active low).
- `ft_txe_n`  in  1: FT600 can accept data (active low).
- `ft_data_in`  in  DATA_W: sampled bus value.
- `ft_data_out`  out  DATA_W: value to drive on the bus.
- `ft_data_oe`  out  1: FPGA drives data/BE pins.
- `ft_be_out`  out  2: byte enables driven during TX.
- `ft_oe_n`, `ft_rd_n`, `ft_wr_n`  out  1 each: FT600 strobes (active low).
- `rx_data`  out  DATA_W: received word.
- `rx_wr_en`  out  1: write strobe into RX FIFO.
- `rx_afull`  in  1: RX FIFO has ≤1 free slot.
- `tx_data`  in  DATA_W: head of TX FIFO (first-word fall-through).
- `tx_empty`  in  1: TX FIFO empty.
- `tx_rd_en`  out  1: pop TX FIFO.
- `busy`  out  1: state ≠ IDLE.

## Operation
- States: IDLE, RX_OE, RX, RX_END, TX.
- Requests in IDLE: `rx_req = !ft_rxf_n && !rx_afull`; `tx_req = !ft_txe_n && !tx_empty`.
- Arbitration: if only one request is present, grant it. If both are present, grant the direction opposite to `last_dir`. `last_dir` resets to TX, so RX wins the first tie. `last_dir` updates on each grant.
- IDLE→RX_OE (RX grant): `ft_oe_n`=0, `ft_rd_n`=1, bus not driven.
- RX_OE→RX unconditionally. In RX: `ft_oe_n`=0, `ft_rd_n`=0.
- In RX: `rx_wr_en = !ft_rxf_n`, `rx_data = ft_data_in` (combinational).
- RX exit to RX_END when, at the clock edge, `ft_rxf_n`=1, or `rx_afull`=1, or the accepted-word count reaches MAX_BURST. The word present in the exit cycle is still accepted.
- RX_END: `ft_oe_n`=1, `ft_rd_n`=1, no drive (turnaround). Always →IDLE.
- IDLE→TX (TX grant): `ft_data_oe`=1, `ft_be_out`=2'b11, `ft_data_out=tx_data`.
- In TX: `ft_wr_n = !tx_rd_en`, with `tx_rd_en = !ft_txe_n && !tx_empty`.
- TX exit to IDLE when `ft_txe_n`=1, or `tx_empty`=1, or the count reaches MAX_BURST. `ft_data_oe` drops on entering IDLE.
- Burst counter: 16-bit. Clears on every IDLE exit. Increments on each `rx_wr_en` or `tx_rd_en`. Exit when count+1 == MAX_BURST on a transferring cycle.
- The FPGA never drives the bus while `ft_oe_n`=0. The RX_END→IDLE→TX path guarantees ≥2 idle cycles between an RX burst and a TX burst.

## Timing
- Reset values: state IDLE, `ft_oe_n`=1, `ft_rd_n`=1, `ft_wr_n`=1, `ft_data_oe`=0, `ft_be_out`=0, `ft_data_out`=0, `rx_wr_en`=0, `tx_rd_en`=0, `busy`=0, `last_dir`=TX, counter=0.
- State and counter are registered. Strobes are decoded from the registered state, except `rx_wr_en`, `tx_rd_en` and `ft_wr_n`, which are combinational with the FT flags.
- RX latency: grant edge → `ft_oe_n` low; +1 cycle → `ft_rd_n` low; first word written the same cycle if `ft_rxf_n`=0.
- TX latency: grant edge → first word written that cycle if `ft_txe_n`=0.
- Flags deasserting mid-burst: transfers pause combinationally; the state exits at the next edge.
- Reset mid-burst: all strobes return high and the bus is released asynchronously. No partial-word recovery.

## Configuration
- `FT600_STATS_EN` defined: adds outputs `rx_count` and `tx_count` (32-bit each).
  - Each increments on `rx_wr_en` / `tx_rd_en` and wraps at 2^32.
  - Both reset to 0.
- `FT600_STATS_EN` undefined: these ports and registers are absent. Behaviour is otherwise identical.

## Structure
- `ft600_pkg`: state enum, `DIR_RX`/`DIR_TX` constants, default bus width, BE constant 2'b11.
- One sub-module, `ft600_burst_cnt`: clear, increment and limit-hit output, parameterised by MAX_BURST.

## Test plan
- Reset held, then released with both flags high → all outputs at reset values; stays IDLE for 100 cycles.
- `ft_rxf_n`=0 for 5 words, `rx_afull`=0 → `ft_oe_n` low one cycle before `ft_rd_n`; exactly 5 `rx_wr_en` pulses; RX_END then IDLE.
- `ft_txe_n`=0, TX FIFO holding 3 words → 3 `tx_rd_en` pulses with `ft_wr_n` low; bus data matches the FIFO order; `ft_data_oe` drops after the last word.
- Both requests held continuously, MAX_BURST=4 → grants alternate RX,TX,RX,TX; each burst is exactly 4 words; no cycle has `ft_data_oe`=1 while `ft_oe_n`=0.
- `rx_afull` asserted during the 3rd RX word → 3rd word accepted, exit to RX_END, no 4th write.
- `rst_n` pulsed low mid-TX → `ft_wr_n`=1 and `ft_data_oe`=0 immediately; with stats enabled, the counters read 0.
